// File: rtl/banked_data_mem.sv
// Purpose : byte-lane banked data memory for the load/store unit; byte and word access,
//           sign/zero-extended byte loads, misaligned words split across two rows.
// Latency : 1 cycle from accept to rsp_valid; 2 cycles for a split misaligned word.
// Backpr. : req_ready drops for the single SPLIT cycle only; responses cannot be stalled.
// Build option DMEM_MISALIGN_EN: when defined, misaligned words run through the SPLIT
//   state; when undefined they fault (rsp_err) and req_ready is tied high.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_size, req_signed  store/load, byte/word, sign-extend byte loads
//   req_addr, req_wdata         byte address, store data (byte store uses [7:0])
//   rsp_valid, rsp_rdata, rsp_err  one-cycle response pulse, load data, fault flag
module banked_data_mem #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ROW_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CAP    = DEPTH_WORDS * LANES;

  // One byte-wide bank per lane; contents are deliberately not reset.
  logic [7:0] mem [LANES][DEPTH_WORDS];

  // Phase-2 context: in the default build these are tied off and never selected.
  logic                    in_split;
  logic [LANE_W-1:0]       cur_lane;
  logic [ROW_W-1:0]        cur_row1;
  logic [DATA_W-1:0]       cur_wdata;
  logic                    cur_we;
  logic [LANES-1:0][7:0]   cur_stage;

  // Request decode and per-lane datapath
  int                      lane_i;
  int                      row_i;
  logic                    mis;
  logic                    fault;
  logic                    accept;
  logic                    go_split;
  logic [LANES-1:0]        wr_en;
  logic [LANES-1:0][ROW_W-1:0] lane_row;
  logic [LANES-1:0][7:0]   wr_byte;
  logic [LANES-1:0][7:0]   rd_byte;
  logic [LANES-1:0][7:0]   merged;
  logic [DATA_W-1:0]       word_v;
  logic [7:0]              byte_v;
  logic [DATA_W-1:0]       load_data;

`ifdef DMEM_MISALIGN_EN
  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;
  state_t                  state;
  logic [LANE_W-1:0]       sp_lane;
  logic [ROW_W-1:0]        sp_row1;
  logic [DATA_W-1:0]       sp_wdata;
  logic                    sp_we;
  logic [LANES-1:0][7:0]   sp_stage;

  assign in_split  = (state == SPLIT);
  assign req_ready = (state == IDLE);
  assign cur_lane  = sp_lane;
  assign cur_row1  = sp_row1;
  assign cur_wdata = sp_wdata;
  assign cur_we    = sp_we;
  assign cur_stage = sp_stage;
`else
  assign in_split  = 1'b0;
  assign req_ready = 1'b1;
  assign cur_lane  = '0;
  assign cur_row1  = '0;
  assign cur_wdata = '0;
  assign cur_we    = 1'b0;
  assign cur_stage = '0;
`endif

  always_comb begin
    int op_lane;
    int k;
    lane_i = int'(req_addr) % LANES;
    row_i  = int'(req_addr) / LANES;
    mis    = req_size && (lane_i != 0);

    if (!req_size) begin
      fault = (int'(req_addr) >= CAP);
    end else if (mis) begin
`ifdef DMEM_MISALIGN_EN
      // The second half lives in row r+1, which must not run off the end.
      fault = (row_i + 1 >= DEPTH_WORDS);
`else
      fault = 1'b1;
`endif
    end else begin
      fault = (row_i >= DEPTH_WORDS);
    end

    accept   = req_valid && req_ready && rst_n;
    go_split = accept && mis && !fault;
    op_lane  = in_split ? int'(cur_lane) : lane_i;

    for (int j = 0; j < LANES; j++) begin
      // k: which byte of the word lands in lane j
      k = (j + LANES - op_lane) % LANES;
      if (in_split) begin
        // Phase 2: lanes below the start lane, one row up.
        lane_row[j] = cur_row1;
        wr_en[j]    = cur_we && (j < op_lane) && rst_n;
        wr_byte[j]  = cur_wdata[k*8 +: 8];
      end else begin
        // Phase 1 / single phase: only lanes at or above the start lane for words.
        lane_row[j] = ROW_W'(row_i);
        wr_en[j]    = accept && req_we && !fault &&
                      (req_size ? (j >= lane_i) : (j == lane_i));
        wr_byte[j]  = req_size ? req_wdata[k*8 +: 8] : req_wdata[7:0];
      end
      rd_byte[j] = mem[j][lane_row[j]];
      // In SPLIT the upper lanes come from the phase-1 staging register.
      merged[j]  = (in_split && (j >= op_lane)) ? cur_stage[j] : rd_byte[j];
    end

    word_v = '0;
    for (int b = 0; b < LANES; b++) begin
      word_v[b*8 +: 8] = merged[(op_lane + b) % LANES];
    end

    byte_v = rd_byte[lane_i];
    if (in_split || req_size) begin
      load_data = word_v;
    end else if (req_signed) begin
      load_data = DATA_W'($signed(byte_v));
    end else begin
      load_data = DATA_W'(byte_v);
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (wr_en[j]) begin
        mem[j][lane_row[j]] <= wr_byte[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef DMEM_MISALIGN_EN
      state     <= IDLE;
      sp_lane   <= '0;
      sp_row1   <= '0;
      sp_wdata  <= '0;
      sp_we     <= 1'b0;
      sp_stage  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (in_split) begin
`ifdef DMEM_MISALIGN_EN
        state <= IDLE;
`endif
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        rsp_rdata <= cur_we ? '0 : load_data;
      end else if (accept) begin
        if (go_split) begin
`ifdef DMEM_MISALIGN_EN
          state    <= SPLIT;
          sp_lane  <= LANE_W'(lane_i);
          sp_row1  <= ROW_W'(row_i + 1);
          sp_wdata <= req_wdata;
          sp_we    <= req_we;
          sp_stage <= rd_byte;
`endif
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= fault;
          rsp_rdata <= (fault || req_we) ? '0 : load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_banked_data_mem.sv
module tb_banked_data_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  banked_data_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH_WORDS(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] d;
    logic        e;
    int          c;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Scoreboard monitor: every response must match the oldest expectation, including cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (q.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        e = q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.d));
        chk("rsp_err", 32'(rsp_err), 32'(e.e));
        chk("rsp_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  task automatic issue(input bit we, input bit size, input bit sgn,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_d, input bit exp_e,
                       input int lat, input bit want);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail_now("ready_timeout");
      req_valid = 1'b0;
      return;
    end
    if (want) begin
      e.d = exp_d;
      e.e = exp_e;
      e.c = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Reset pulse placed mid-cycle; outputs must clear immediately.
  task automatic reset_pulse(input bit sync_negedge);
    if (sync_negedge) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    // 1. reset state
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", 32'(rsp_valid), 32'd0);
    chk("init_err", 32'(rsp_err), 32'd0);
    chk("init_rdata", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("init_ready", 32'(req_ready), 32'd1);

    // 2. aligned word store then load, then mid-cycle reset with nonzero rdata
    issue(1, 1, 0, 16'h0010, 16'hBEEF, 16'h0000, 0, 1, 1);
    issue(0, 1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, 1);
    reset_pulse(1);
    issue(1, 1, 0, 16'h0000, 16'h7788, 16'h0000, 0, 1, 1);

    // 3. byte accesses
    issue(0, 0, 1, 16'h0010, 16'h0000, 16'hFFEF, 0, 1, 1);
    issue(0, 0, 0, 16'h0011, 16'h0000, 16'h00BE, 0, 1, 1);
    issue(0, 0, 0, 16'h0010, 16'h0000, 16'h00EF, 0, 1, 1);
    issue(1, 0, 0, 16'h0011, 16'hC35A, 16'h0000, 0, 1, 1);
    issue(0, 1, 0, 16'h0010, 16'h0000, 16'h5AEF, 0, 1, 1);
    issue(0, 0, 1, 16'h0011, 16'h0000, 16'h005A, 0, 1, 1);

    // 4. misaligned word
    issue(1, 1, 0, 16'h0020, 16'h77CC, 16'h0000, 0, 1, 1);
    issue(1, 1, 0, 16'h0022, 16'h9966, 16'h0000, 0, 1, 1);
`ifdef DMEM_MISALIGN_EN
    issue(1, 1, 0, 16'h0021, 16'h1234, 16'h0000, 0, 2, 1);
    #2 chk("ready_in_split", 32'(req_ready), 32'd0);
    issue(0, 0, 0, 16'h0021, 16'h0000, 16'h0034, 0, 1, 1);
    issue(0, 0, 0, 16'h0022, 16'h0000, 16'h0012, 0, 1, 1);
    issue(0, 1, 0, 16'h0021, 16'h0000, 16'h1234, 0, 2, 1);
    issue(0, 1, 0, 16'h0020, 16'h0000, 16'h34CC, 0, 1, 1);
    issue(0, 1, 0, 16'h0022, 16'h0000, 16'h9912, 0, 1, 1);
`else
    issue(1, 1, 0, 16'h0021, 16'h1234, 16'h0000, 1, 1, 1);
    #2 chk("ready_no_split", 32'(req_ready), 32'd1);
    issue(0, 1, 0, 16'h0020, 16'h0000, 16'h77CC, 0, 1, 1);
    issue(0, 1, 0, 16'h0022, 16'h0000, 16'h9966, 0, 1, 1);
    issue(0, 1, 0, 16'h0021, 16'h0000, 16'h0000, 1, 1, 1);
`endif

    // 5. faults and top-of-memory boundary
    issue(0, 1, 0, 16'h0100, 16'h0000, 16'h0000, 1, 1, 1);
    issue(0, 0, 0, 16'h0100, 16'h0000, 16'h0000, 1, 1, 1);
    issue(1, 0, 0, 16'h0100, 16'h0011, 16'h0000, 1, 1, 1);
    issue(0, 1, 0, 16'h0000, 16'h0000, 16'h7788, 0, 1, 1);
    issue(1, 1, 0, 16'h00FE, 16'h55AA, 16'h0000, 0, 1, 1);
    issue(1, 0, 0, 16'h00FF, 16'h003C, 16'h0000, 0, 1, 1);
    issue(0, 1, 0, 16'h00FE, 16'h0000, 16'h3CAA, 0, 1, 1);
    issue(1, 1, 0, 16'h00FF, 16'hDEAD, 16'h0000, 1, 1, 1);
    issue(0, 1, 0, 16'h00FE, 16'h0000, 16'h3CAA, 0, 1, 1);
    issue(0, 0, 0, 16'h00FF, 16'h0000, 16'h003C, 0, 1, 1);

    // 6. reset during a split store
    issue(1, 1, 0, 16'h0030, 16'h2211, 16'h0000, 0, 1, 1);
    issue(1, 1, 0, 16'h0032, 16'h4433, 16'h0000, 0, 1, 1);
    issue(0, 1, 0, 16'h0032, 16'h0000, 16'h4433, 0, 1, 1);
`ifdef DMEM_MISALIGN_EN
    issue(1, 1, 0, 16'h0031, 16'hA5C3, 16'h0000, 0, 2, 0);
    #1 chk("ready_before_abort", 32'(req_ready), 32'd0);
    reset_pulse(0);
    issue(0, 0, 0, 16'h0031, 16'h0000, 16'h00C3, 0, 1, 1);
    issue(0, 0, 0, 16'h0032, 16'h0000, 16'h0033, 0, 1, 1);
    issue(0, 1, 0, 16'h0030, 16'h0000, 16'hC311, 0, 1, 1);
`else
    issue(1, 1, 0, 16'h0031, 16'hA5C3, 16'h0000, 1, 1, 1);
    issue(0, 1, 0, 16'h0030, 16'h0000, 16'h2211, 0, 1, 1);
    issue(0, 1, 0, 16'h0032, 16'h0000, 16'h4433, 0, 1, 1);
    reset_pulse(1);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
